ifetch_queue: RTL and testbench
===============================

// Module: ifetch_queue
// PURPOSE
//  Instruction fetch stage feeding the unified cache's fetch port and buffering fetched words for the decoder.
//  Holds the fetch PC and requests one 32-bit word at a time from the cache.
//  Predecodes JAL so the next fetch PC follows the jump target.
//  Pushes (inst, pc, next_pc) into a circular queue drained by the decoder; flushes and redirects on rob_clear_up.
// PARAMETERS
//  QLOG      2             log2 of queue depth (DEPTH = 1<<QLOG = 4 entries)
//  RESET_PC  32'h00000000  fetch PC after reset
// PORTS
//  clk_in          in   1   system clock
//  rst_n_in        in   1   asynchronous, active-low reset
//  rdy_in          in   1   global ready; when low every register holds its value
//  rob_clear_up    in   1   flush: drop queue contents and the in-flight fetch, then redirect
//  redirect_pc     in   32  new fetch PC, sampled when rob_clear_up=1
//  start_fetch     out  1   fetch request to cache, level, held while state=REQ
//  pc              out  32  fetch address to cache; stable while start_fetch=1
//  fetch_ready     in   1   cache returns a fetched word this cycle
//  inst            in   32  fetched word, valid with fetch_ready
//  inst_addr       in   32  address of fetched word, valid with fetch_ready
//  dec_valid       out  1   queue head valid (count!=0)
//  dec_inst        out  32  head instruction
//  dec_pc          out  32  head instruction address
//  dec_pred_pc     out  32  predicted next PC of head (JAL target or pc+4)
//  dec_ready       in   1   decoder consumes head when dec_valid && dec_ready
// BEHAVIOUR
//  Reset (rst_n_in=0, async):
//   - state=IDLE, fetch_pc=RESET_PC, head=tail=0, count=0.
//   - Outputs: start_fetch=0, pc=RESET_PC, dec_valid=0; dec_* data outputs are 0.
//  Freeze: rdy_in=0 holds all state; start_fetch and pc keep their values.
//  Priority: reset > rob_clear_up > normal operation.
//  States (registered):
//   - IDLE: start_fetch=0. Go to REQ when count<DEPTH.
//   - REQ: start_fetch=1, pc=fetch_pc.
//     - Response accepted when fetch_ready && inst_addr==fetch_pc: push {inst, fetch_pc, npc}; fetch_pc<=npc.
//     - After accept: stay REQ when space remains (count_next<DEPTH), else IDLE.
//     - fetch_ready with inst_addr!=fetch_pc is ignored (stale word from before a flush).
//   - FLUSH: one-cycle bubble after a clear; start_fetch=0; next state is IDLE.
//  npc (combinational from inst):
//   - inst[6:0]==7'b1101111 (JAL): npc = fetch_pc + sext({inst[31],inst[19:12],inst[20],inst[30:21],1'b0}).
//   - Otherwise: npc = fetch_pc+4.
//   - 32-bit modular arithmetic; wrap past 32'hFFFFFFFC is allowed.
//  Queue: DEPTH entries, circular, head/tail pointers QLOG bits wide, wrap modulo DEPTH; count is QLOG+1 bits.
//   - pop = dec_valid && dec_ready; head advances.
//   - push only when count<DEPTH || pop (full + simultaneous pop + push is legal); tail advances.
//   - pop and push in the same cycle: count unchanged.
//   - Outputs dec_* driven from head entry, registered storage, no bypass: a pushed word is visible the cycle after the push.
//  Flush (rob_clear_up=1 and rdy_in=1):
//   - head=tail=0, count=0, dec_valid=0 next cycle.
//   - fetch_pc<=redirect_pc; state<=FLUSH.
//   - Any response in the flush cycle is discarded; no pop happens in the flush cycle.
//   - The cache aborts its own fetch on rob_clear_up, so no response is awaited afterwards.
//  Latency: cache return to dec_valid is 1 cycle. Back-to-back fetches re-assert start_fetch the cycle after fetch_ready.
// TESTING
//  1. Reset, cache model answering 4 cycles after request, dec_ready=1, memory holding addi at 0,4,8
//     -> dec_pc sequence 0,4,8; dec_pred_pc = 4,8,12.
//  2. dec_ready=0 with continuous fetch -> exactly 4 entries, then start_fetch=0 and state IDLE.
//     Raise dec_ready for one cycle -> one pop, start_fetch re-asserted next cycle, pc=16.
//  3. JAL at 0x100 with inst=32'h0100006F (offset +16) -> dec_pred_pc=0x110, next pc=0x110.
//     JAL with offset -4 at 0x200 -> next pc=0x1FC.
//  4. Queue holding 3 entries, REQ in flight, rob_clear_up with redirect_pc=0x400
//     -> dec_valid=0 next cycle, one FLUSH cycle, then start_fetch=1 with pc=0x400.
//     A late fetch_ready with inst_addr=old pc is ignored.
//  5. Full queue with push and pop in the same cycle -> count stays 4, order preserved, pointers wrap 3->0.
//  6. rdy_in low for 5 cycles mid-REQ -> pc, queue and outputs unchanged; fetch completes normally afterwards.
//     rst_n_in pulsed low mid-REQ -> all outputs at reset values immediately (async), pc=RESET_PC.

Source files
------------

// File: rtl/ifetch_queue.sv
// Instruction fetch stage: single-word fetch FSM with JAL predecode, pushing
// (inst, pc, next_pc) into a small circular queue drained by the decoder.
module ifetch_queue #(
  parameter int          QLOG     = 2,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic        rdy_in,
  input  logic        rob_clear_up,
  input  logic [31:0] redirect_pc,
  output logic        start_fetch,
  output logic [31:0] pc,
  input  logic        fetch_ready,
  input  logic [31:0] inst,
  input  logic [31:0] inst_addr,
  output logic        dec_valid,
  output logic [31:0] dec_inst,
  output logic [31:0] dec_pc,
  output logic [31:0] dec_pred_pc,
  input  logic        dec_ready
);

  localparam int            DEPTH     = 1 << QLOG;
  localparam logic [QLOG:0] DEPTH_CNT = (QLOG + 1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_FLUSH = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_next;
  logic [31:0]     r_fetch_pc;
  logic [QLOG-1:0] r_head;
  logic [QLOG-1:0] r_tail;
  logic [QLOG:0]   r_count;
  logic [QLOG:0]   w_count_next;
  logic [31:0]     r_inst_q [DEPTH];
  logic [31:0]     r_pc_q   [DEPTH];
  logic [31:0]     r_npc_q  [DEPTH];

  logic            w_is_jal;
  logic [31:0]     w_jal_off;
  logic [31:0]     w_npc;
  logic            w_pop;
  logic            w_space;
  logic            w_push;

  assign w_is_jal  = (inst[6:0] == 7'b1101111);
  assign w_jal_off = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
  assign w_npc     = w_is_jal ? (r_fetch_pc + w_jal_off) : (r_fetch_pc + 32'd4);

  // Stale words (address mismatch) left over from before a flush are dropped here.
  assign w_pop   = (r_count != {(QLOG+1){1'b0}}) && dec_ready && !rob_clear_up;
  assign w_space = (r_count < DEPTH_CNT) || w_pop;
  assign w_push  = (r_state == S_REQ) && fetch_ready && (inst_addr == r_fetch_pc)
                   && !rob_clear_up && w_space;

  // Occupancy after this cycle's push/pop
  always_comb begin
    w_count_next = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_next = r_count + 1'b1;
      2'b01:   w_count_next = r_count - 1'b1;
      default: w_count_next = r_count;
    endcase
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    if (rob_clear_up) begin
      w_state_next = S_FLUSH;
    end else begin
      case (r_state)
        S_IDLE:  w_state_next = (w_count_next < DEPTH_CNT) ? S_REQ : S_IDLE;
        S_REQ: begin
          if (w_push) begin
            w_state_next = (w_count_next < DEPTH_CNT) ? S_REQ : S_IDLE;
          end else begin
            w_state_next = S_REQ;
          end
        end
        S_FLUSH: w_state_next = S_IDLE;
        default: w_state_next = S_IDLE;
      endcase
    end
  end

  // Output decode
  always_comb begin
    start_fetch = 1'b0;
    case (r_state)
      S_REQ:   start_fetch = 1'b1;
      default: start_fetch = 1'b0;
    endcase
  end

  assign pc          = r_fetch_pc;
  assign dec_valid   = (r_count != {(QLOG+1){1'b0}});
  assign dec_inst    = r_inst_q[r_head];
  assign dec_pc      = r_pc_q[r_head];
  assign dec_pred_pc = r_npc_q[r_head];

  // State register
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_state <= S_IDLE;
    end else if (rdy_in) begin
      r_state <= w_state_next;
    end
  end

  // Fetch PC: follows the predicted next PC, or the redirect on a flush
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_fetch_pc <= RESET_PC;
    end else if (rdy_in) begin
      if (rob_clear_up) begin
        r_fetch_pc <= redirect_pc;
      end else if (w_push) begin
        r_fetch_pc <= w_npc;
      end
    end
  end

  // Queue pointers and occupancy
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_head  <= {QLOG{1'b0}};
      r_tail  <= {QLOG{1'b0}};
      r_count <= {(QLOG+1){1'b0}};
    end else if (rdy_in) begin
      if (rob_clear_up) begin
        r_head  <= {QLOG{1'b0}};
        r_tail  <= {QLOG{1'b0}};
        r_count <= {(QLOG+1){1'b0}};
      end else begin
        if (w_push) begin
          r_tail <= r_tail + 1'b1;
        end
        if (w_pop) begin
          r_head <= r_head + 1'b1;
        end
        r_count <= w_count_next;
      end
    end
  end

  // Queue storage
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_inst_q[i] <= 32'h0000_0000;
        r_pc_q[i]   <= 32'h0000_0000;
        r_npc_q[i]  <= 32'h0000_0000;
      end
    end else if (rdy_in && w_push) begin
      r_inst_q[r_tail] <= inst;
      r_pc_q[r_tail]   <= r_fetch_pc;
      r_npc_q[r_tail]  <= w_npc;
    end
  end

endmodule

// File: tb/tb_ifetch_queue.sv
// Scoreboard bench for ifetch_queue: a latency-modelled cache answers fetches,
// a reference model predicts queue contents, a monitor checks every pop.
module tb_ifetch_queue;

  logic        clk_in = 1'b0;
  logic        rst_n_in = 1'b0;
  logic        rdy_in = 1'b1;
  logic        rob_clear_up = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        start_fetch;
  logic [31:0] pc;
  logic        fetch_ready = 1'b0;
  logic [31:0] inst = 32'h0;
  logic [31:0] inst_addr = 32'h0;
  logic        dec_valid;
  logic [31:0] dec_inst;
  logic [31:0] dec_pc;
  logic [31:0] dec_pred_pc;
  logic        dec_ready = 1'b0;

  ifetch_queue #(.QLOG(2), .RESET_PC(32'h0000_0000)) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .rdy_in(rdy_in),
    .rob_clear_up(rob_clear_up), .redirect_pc(redirect_pc),
    .start_fetch(start_fetch), .pc(pc),
    .fetch_ready(fetch_ready), .inst(inst), .inst_addr(inst_addr),
    .dec_valid(dec_valid), .dec_inst(dec_inst), .dec_pc(dec_pc),
    .dec_pred_pc(dec_pred_pc), .dec_ready(dec_ready)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] npc;
  } ent_t;

  ent_t        sb[$];
  ent_t        pop_log[$];
  ent_t        mon_e;
  int          checks = 0;
  int          failures = 0;

  logic [31:0] m_pc = 32'h0;
  bit          pend_push = 1'b0;
  bit          pend_clear = 1'b0;
  ent_t        pend_ent;
  logic [31:0] pend_redirect = 32'h0;

  bit          busy = 1'b0;
  int          cnt = 0;
  logic [31:0] req_addr = 32'h0;
  bit          req_now = 1'b0;
  bit          lat_rand = 1'b0;
  bit          stale_en = 1'b0;
  logic [31:0] stale_addr = 32'h0;

  bit          t_rdy = 1'b1;
  bit          t_dready = 1'b1;
  bit          t_clear = 1'b0;
  logic [31:0] t_redirect = 32'h0;

  logic [31:0] cap_pc;
  logic [31:0] cap_dpc;
  logic        cap_dv;
  bit          found;

  // Memory image: fixed JALs at 0x100/0x200, a +32 JAL at every addr[4:2]==5, addi elsewhere
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0000_0100) return 32'h0100_006F;
    if (a == 32'h0000_0200) return 32'hFFDF_F06F;
    if (a[4:2] == 3'b101)   return 32'h0200_006F;
    return {a[11:0], 5'd0, 3'd0, 5'd1, 7'h13};
  endfunction

  function automatic logic [31:0] ref_npc(input logic [31:0] w, input logic [31:0] a);
    logic signed [20:0] imm;
    if (w[6:0] != 7'h6F) return a + 32'd4;
    imm = {w[31], w[19:12], w[20], w[30:21], 1'b0};
    return a + 32'(imm);
  endfunction

  task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic commit();
    if (pend_clear) begin
      sb.delete();
      m_pc = pend_redirect;
    end else if (pend_push) begin
      sb.push_back(pend_ent);
      m_pc = pend_ent.npc;
    end
    pend_clear = 1'b0;
    pend_push  = 1'b0;
  endtask

  task automatic drive();
    bit pop_now;
    rdy_in       = t_rdy;
    dec_ready    = t_dready;
    rob_clear_up = t_clear;
    redirect_pc  = t_redirect;
    fetch_ready  = 1'b0;
    req_now      = 1'b0;
    if (t_clear) begin
      busy = 1'b0;
    end else if (busy) begin
      if (t_rdy) begin
        cnt--;
        if (cnt == 0) begin
          fetch_ready = 1'b1;
          inst        = mem_word(req_addr);
          inst_addr   = req_addr;
          busy        = 1'b0;
        end
      end
    end else if (start_fetch && t_rdy) begin
      check_eq("fetch_pc", pc, m_pc);
      busy     = 1'b1;
      req_addr = pc;
      cnt      = lat_rand ? int'($urandom_range(1, 5)) : 4;
      req_now  = 1'b1;
    end
    if (stale_en && req_now) begin
      fetch_ready = 1'b1;
      inst        = 32'h0000_0013;
      inst_addr   = stale_addr;
      stale_en    = 1'b0;
    end
    pop_now = (sb.size() != 0) && t_dready && t_rdy && !t_clear;
    if (t_clear && t_rdy) begin
      pend_clear    = 1'b1;
      pend_redirect = t_redirect;
    end else if (fetch_ready && t_rdy && inst_addr == m_pc && (sb.size() < 4 || pop_now)) begin
      pend_push = 1'b1;
      pend_ent  = '{inst, m_pc, ref_npc(inst, m_pc)};
    end
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
    commit();
    drive();
  endtask

  task automatic model_reset();
    sb.delete();
    pend_clear = 1'b0;
    pend_push  = 1'b0;
    busy       = 1'b0;
    m_pc       = 32'h0;
    t_clear    = 1'b0;
  endtask

  task automatic do_reset();
    rst_n_in     = 1'b0;
    fetch_ready  = 1'b0;
    rob_clear_up = 1'b0;
    model_reset();
    @(posedge clk_in);
    #1;
    rst_n_in = 1'b1;
    drive();
  endtask

  task automatic wait_req(input logic [31:0] a, input string name);
    bit hit = 1'b0;
    for (int i = 0; i < 60 && !hit; i++) begin
      step();
      if (req_now && req_addr == a) hit = 1'b1;
    end
    check_eq(name, {31'd0, hit}, 32'd1);
  endtask

  // Monitor: checks occupancy every cycle and the head entry on every pop
  always @(negedge clk_in) begin
    if (rst_n_in) begin
      check_eq("dec_valid", {31'd0, dec_valid}, {31'd0, sb.size() != 0});
      if (dec_valid && dec_ready && rdy_in && !rob_clear_up && sb.size() != 0) begin
        mon_e = sb.pop_front();
        pop_log.push_back('{dec_inst, dec_pc, dec_pred_pc});
        check_eq("dec_inst", dec_inst, mon_e.inst);
        check_eq("dec_pc", dec_pc, mon_e.pc);
        check_eq("dec_pred_pc", dec_pred_pc, mon_e.npc);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values
    #12;
    check_eq("rst_start_fetch", {31'd0, start_fetch}, 32'd0);
    check_eq("rst_pc", pc, 32'h0);
    check_eq("rst_dec_valid", {31'd0, dec_valid}, 32'd0);
    check_eq("rst_dec_inst", dec_inst, 32'h0);
    check_eq("rst_dec_pc", dec_pc, 32'h0);
    check_eq("rst_dec_pred_pc", dec_pred_pc, 32'h0);
    @(posedge clk_in);
    #1;
    rst_n_in = 1'b1;
    drive();

    // Sequential addi stream
    pop_log.delete();
    repeat (30) step();
    check_eq("t1_pops", {31'd0, pop_log.size() >= 3}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      if (i < pop_log.size()) begin
        check_eq("t1_pc", pop_log[i].pc, 32'(4 * i));
        check_eq("t1_pred", pop_log[i].npc, 32'(4 * i + 4));
      end
    end

    // Fill to capacity with the decoder stalled
    t_dready = 1'b0;
    do_reset();
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      step();
      if (sb.size() == 4 && !start_fetch) found = 1'b1;
    end
    check_eq("t2_full", {31'd0, found}, 32'd1);
    repeat (8) step();
    check_eq("t2_idle", {31'd0, start_fetch}, 32'd0);
    check_eq("t2_head", dec_pc, 32'h0);
    t_dready = 1'b1;
    step();
    t_dready = 1'b0;
    step();
    check_eq("t2_refetch", {31'd0, start_fetch}, 32'd1);
    check_eq("t2_pc", pc, 32'd16);

    // JAL predecode
    t_dready   = 1'b1;
    t_clear    = 1'b1;
    t_redirect = 32'h0000_0100;
    step();
    t_clear = 1'b0;
    pop_log.delete();
    wait_req(32'h0000_0100, "t3_req_100");
    wait_req(32'h0000_0110, "t3_req_110");
    repeat (3) step();
    check_eq("t3_pops", {31'd0, pop_log.size() >= 1}, 32'd1);
    if (pop_log.size() >= 1) begin
      check_eq("t3_jal_pc", pop_log[0].pc, 32'h0000_0100);
      check_eq("t3_jal_pred", pop_log[0].npc, 32'h0000_0110);
    end
    t_clear    = 1'b1;
    t_redirect = 32'h0000_0200;
    step();
    t_clear = 1'b0;
    wait_req(32'h0000_0200, "t3_req_200");
    wait_req(32'h0000_01FC, "t3_req_1fc");

    // Flush with 3 entries queued and a fetch in flight
    t_dready = 1'b0;
    do_reset();
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      step();
      if (sb.size() == 3 && busy) found = 1'b1;
    end
    check_eq("t4_setup", {31'd0, found}, 32'd1);
    stale_addr = m_pc;
    t_clear    = 1'b1;
    t_redirect = 32'h0000_0400;
    step();
    t_clear = 1'b0;
    step();
    check_eq("t4_flush_valid", {31'd0, dec_valid}, 32'd0);
    check_eq("t4_flush_sf", {31'd0, start_fetch}, 32'd0);
    stale_en = 1'b1;
    wait_req(32'h0000_0400, "t4_req_400");
    repeat (10) step();
    check_eq("t4_head", dec_pc, 32'h0000_0400);

    // Freeze mid-request
    t_dready = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      step();
      if (busy && sb.size() != 0) found = 1'b1;
    end
    check_eq("t6_setup", {31'd0, found}, 32'd1);
    t_rdy = 1'b0;
    step();
    cap_pc  = pc;
    cap_dv  = dec_valid;
    cap_dpc = dec_pc;
    repeat (5) step();
    check_eq("t6_pc", pc, cap_pc);
    check_eq("t6_sf", {31'd0, start_fetch}, 32'd1);
    check_eq("t6_dv", {31'd0, dec_valid}, {31'd0, cap_dv});
    check_eq("t6_dpc", dec_pc, cap_dpc);
    t_rdy = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      step();
      if (pc != cap_pc) found = 1'b1;
    end
    check_eq("t6_resume", {31'd0, found}, 32'd1);

    // Asynchronous reset pulse mid-request with a non-empty queue
    t_dready = 1'b0;
    repeat (15) step();
    #2;
    rst_n_in = 1'b0;
    #1;
    check_eq("t6_arst_sf", {31'd0, start_fetch}, 32'd0);
    check_eq("t6_arst_pc", pc, 32'h0);
    check_eq("t6_arst_dv", {31'd0, dec_valid}, 32'd0);
    check_eq("t6_arst_dinst", dec_inst, 32'h0);
    fetch_ready = 1'b0;
    model_reset();
    @(posedge clk_in);
    #1;
    rst_n_in = 1'b1;
    drive();

    // Randomized traffic: stalls, freezes, flushes (some near the top of memory)
    lat_rand = 1'b1;
    repeat (2000) begin
      t_rdy    = ($urandom_range(0, 9) != 0);
      t_dready = ($urandom_range(0, 2) != 0);
      t_clear  = ($urandom_range(0, 60) == 0);
      if (t_clear) begin
        t_rdy = 1'b1;
        if ($urandom_range(0, 3) == 0)
          t_redirect = 32'hFFFF_FFF0 + (32'($urandom_range(0, 3)) << 2);
        else
          t_redirect = 32'($urandom_range(0, 1023)) << 2;
      end
      step();
    end
    t_rdy    = 1'b1;
    t_dready = 1'b1;
    t_clear  = 1'b0;
    repeat (20) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
